// File: rtl/seq_inject_ctrl_pkg.sv
// Shared opcodes, interrupt vector and sequencer state encoding for the
// control-flow injection sequencer.
package pipe_ctrl_pkg;

    localparam logic [15:0] OP_PUSH_PC_LOW  = 16'h6008;
    localparam logic [15:0] OP_PUSH_PC_HIGH = 16'h6009;
    localparam logic [15:0] OP_PUSH_FLAGS   = 16'h600A;
    localparam logic [15:0] OP_POP_PC_HIGH  = 16'h7009;
    localparam logic [15:0] OP_POP_PC_LOW   = 16'h7008;

    localparam logic [31:0] INT_VECTOR = 32'h0000_0020;

    typedef enum logic [3:0] {
        IDLE,
        CALL_LO,
        CALL_HI,
        INT_LO,
        INT_HI,
        INT_FLAGS,
        RET_HI,
        RET_LO,
        RET_WAIT,
        REDIRECT
    } state_t;

endpackage

// File: rtl/seq_inject_ctrl_if.sv
// Request/memory inputs and injection/redirect outputs of the sequencer.
// The slave side is the sequencer; the master side is the surrounding pipeline.
interface seq_inject_ctrl_if;
    logic        int_req;
    logic        call_req;
    logic        ret_req;
    logic [15:0] target;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;
    logic [15:0] inj_instr;
    logic        inj_valid;
    logic        stall;
    logic        change_pc;
    logic [31:0] new_pc;
    logic        int_ack;
    logic        busy;

    modport master (
        output int_req, call_req, ret_req, target, mem_data_in, mem_data_valid,
        input  inj_instr, inj_valid, stall, change_pc, new_pc, int_ack, busy
    );

    modport slave (
        input  int_req, call_req, ret_req, target, mem_data_in, mem_data_valid,
        output inj_instr, inj_valid, stall, change_pc, new_pc, int_ack, busy
    );
endinterface

// File: rtl/seq_inject_ctrl_pc_assembler.sv
// Rebuilds a 32-bit return address from two popped halfwords: the first
// accepted word is the high half, the second the low half.
module pc_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        cap_en,
    input  logic [15:0] data,
    output logic        done,
    output logic        last_cap,
    output logic [31:0] pc
);

    logic [1:0]  count;
    logic [15:0] hi_half;
    logic [15:0] lo_half;
    logic        take;

    // Extra words after both halves are in are dropped, not wrapped.
    assign take = cap_en && (count != 2'd2);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count   <= 2'd0;
            hi_half <= 16'h0000;
            lo_half <= 16'h0000;
        end else if (take) begin
            if (count == 2'd0) begin
                hi_half <= data;
            end else begin
                lo_half <= data;
            end
            count <= count + 2'd1;
        end
    end

    assign done     = (count == 2'd2);
    assign last_cap = take && (count == 2'd1);
    assign pc       = {hi_half, lo_half};

endmodule

// File: rtl/seq_inject_ctrl.sv
// Injects the push/pop micro-ops for CALL, RET and interrupts into decode,
// holds fetch/decode stalled while doing so and issues the final PC redirect.
module seq_inject_ctrl
    import pipe_ctrl_pkg::*;
(
    input logic            clk,
    input logic            reset,
    seq_inject_ctrl_if.slave bus
);

    state_t      state;
    state_t      state_nx;
    logic [31:0] tgt_reg;
    logic        pop_src;
    logic [31:0] tgt;

    logic        asm_clear;
    logic        asm_cap_en;
    logic        asm_done;
    logic        asm_last_cap;
    logic [31:0] asm_pc;

    logic [15:0] inj_instr;
    logic        inj_valid;
    logic        stall;
    logic        change_pc;
    logic [31:0] new_pc;
    logic        int_ack;

    assign asm_clear  = (state == IDLE) && !bus.int_req && !bus.call_req && bus.ret_req;
    assign asm_cap_en = bus.mem_data_valid && ((state == RET_LO) || (state == RET_WAIT));

    pc_assembler u_pc_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (asm_clear),
        .cap_en   (asm_cap_en),
        .data     (bus.mem_data_in),
        .done     (asm_done),
        .last_cap (asm_last_cap),
        .pc       (asm_pc)
    );

    // A RET takes its target from the popped words; CALL/INT from tgt_reg.
    assign tgt = pop_src ? asm_pc : tgt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tgt_reg <= 32'h0000_0000;
            pop_src <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (bus.int_req) begin
                    tgt_reg <= INT_VECTOR;
                    pop_src <= 1'b0;
                end else if (bus.call_req) begin
                    tgt_reg <= {16'h0000, bus.target};
                    pop_src <= 1'b0;
                end else if (bus.ret_req) begin
                    pop_src <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output and the next state get a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        inj_instr = 16'h0000;
        inj_valid = 1'b0;
        stall     = 1'b1;
        change_pc = 1'b0;
        new_pc    = tgt;
        int_ack   = 1'b0;

        unique case (state)
            IDLE: begin
                stall  = 1'b0;
                new_pc = 32'h0000_0000;
                if (bus.int_req) begin
                    state_nx = INT_LO;
                end else if (bus.call_req) begin
                    state_nx = CALL_LO;
                end else if (bus.ret_req) begin
                    state_nx = RET_HI;
                end
            end
            CALL_LO: begin
                inj_instr = OP_PUSH_PC_LOW;
                inj_valid = 1'b1;
                state_nx  = CALL_HI;
            end
            CALL_HI: begin
                inj_instr = OP_PUSH_PC_HIGH;
                inj_valid = 1'b1;
                state_nx  = REDIRECT;
            end
            INT_LO: begin
                inj_instr = OP_PUSH_PC_LOW;
                inj_valid = 1'b1;
                int_ack   = 1'b1;
                state_nx  = INT_HI;
            end
            INT_HI: begin
                inj_instr = OP_PUSH_PC_HIGH;
                inj_valid = 1'b1;
                state_nx  = INT_FLAGS;
            end
            INT_FLAGS: begin
                inj_instr = OP_PUSH_FLAGS;
                inj_valid = 1'b1;
                state_nx  = REDIRECT;
            end
            RET_HI: begin
                inj_instr = OP_POP_PC_HIGH;
                inj_valid = 1'b1;
                state_nx  = RET_LO;
            end
            RET_LO: begin
                inj_instr = OP_POP_PC_LOW;
                inj_valid = 1'b1;
                state_nx  = RET_WAIT;
            end
            RET_WAIT: begin
                // Redirect follows the edge at which the second word lands.
                if (asm_last_cap || asm_done) begin
                    state_nx = REDIRECT;
                end
            end
            REDIRECT: begin
                change_pc = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.inj_instr = inj_instr;
    assign bus.inj_valid = inj_valid;
    assign bus.stall     = stall;
    assign bus.change_pc = change_pc;
    assign bus.new_pc    = new_pc;
    assign bus.int_ack   = int_ack;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_inject_ctrl.sv
// Self-checking bench for seq_inject_ctrl: directed vector table, hand-written
// RET sequence, then random traffic against a transaction-level model.
module tb_seq_inject_ctrl;

    logic clk;
    logic reset;

    seq_inject_ctrl_if bus ();

    seq_inject_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] inj;
        logic        iv;
        logic        stall;
        logic        cp;
        logic [31:0] pc;
        logic        ack;
        logic        busy;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        intr;
        logic        call;
        logic        ret;
        logic [15:0] tgt;
        logic        mv;
        logic [15:0] md;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".inj_instr"}, {16'h0, bus.inj_instr}, {16'h0, e.inj});
        check({tag, ".inj_valid"}, {31'h0, bus.inj_valid}, {31'h0, e.iv});
        check({tag, ".stall"},     {31'h0, bus.stall},     {31'h0, e.stall});
        check({tag, ".change_pc"}, {31'h0, bus.change_pc}, {31'h0, e.cp});
        check({tag, ".new_pc"},    bus.new_pc,             e.pc);
        check({tag, ".int_ack"},   {31'h0, bus.int_ack},   {31'h0, e.ack});
        check({tag, ".busy"},      {31'h0, bus.busy},      {31'h0, e.busy});
    endtask

    function automatic exp_t mk_exp(logic [15:0] inj, logic iv, logic st, logic cp,
                                    logic [31:0] pc, logic ack, logic busy);
        exp_t e;
        e.inj = inj; e.iv = iv; e.stall = st; e.cp = cp;
        e.pc = pc; e.ack = ack; e.busy = busy;
        return e;
    endfunction

    function automatic void add(logic rst, logic i, logic c, logic r, logic [15:0] t,
                                logic mv, logic [15:0] md, exp_t e);
        vec_t v;
        v.rst = rst; v.intr = i; v.call = c; v.ret = r;
        v.tgt = t; v.mv = mv; v.md = md; v.e = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic i, input logic c, input logic r,
                         input logic [15:0] t, input logic mv, input logic [15:0] md);
        reset              = rst;
        bus.int_req        = i;
        bus.call_req       = c;
        bus.ret_req        = r;
        bus.target         = t;
        bus.mem_data_valid = mv;
        bus.mem_data_in    = md;
    endtask

    // Reference model: a macro-op is a list of injected opcodes followed by
    // one redirect cycle; a RET additionally waits until two words popped.
    typedef enum {K_NONE, K_CALL, K_INT, K_RET} kind_t;
    kind_t       m_kind  = K_NONE;
    int          m_step  = 0;
    bit          m_redir = 1'b0;
    int          m_words = 0;
    logic [31:0] m_tgt   = 32'h0;

    function automatic int n_ops(kind_t k);
        return (k == K_INT) ? 3 : 2;
    endfunction

    function automatic logic [15:0] op_of(kind_t k, int s);
        logic [15:0] call_ops [2];
        logic [15:0] int_ops  [3];
        logic [15:0] ret_ops  [2];
        call_ops = '{16'h6008, 16'h6009};
        int_ops  = '{16'h6008, 16'h6009, 16'h600A};
        ret_ops  = '{16'h7009, 16'h7008};
        case (k)
            K_CALL:  return call_ops[s];
            K_INT:   return int_ops[s];
            K_RET:   return ret_ops[s];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_kind = K_NONE; m_step = 0; m_redir = 0; m_words = 0; m_tgt = 32'h0;
        end else if (m_kind == K_NONE) begin
            m_step = 0; m_redir = 0;
            if (bus.int_req) begin
                m_kind = K_INT; m_tgt = 32'h0000_0020;
            end else if (bus.call_req) begin
                m_kind = K_CALL; m_tgt = {16'h0, bus.target};
            end else if (bus.ret_req) begin
                m_kind = K_RET; m_tgt = 32'h0; m_words = 0;
            end
        end else if (m_redir) begin
            m_kind = K_NONE; m_redir = 0;
        end else begin
            if (m_kind == K_RET && m_step >= 1 && bus.mem_data_valid && m_words < 2) begin
                if (m_words == 0) m_tgt[31:16] = bus.mem_data_in;
                else              m_tgt[15:0]  = bus.mem_data_in;
                m_words++;
            end
            if (m_kind != K_RET) begin
                m_step++;
                if (m_step == n_ops(m_kind)) m_redir = 1;
            end else if (m_step < 2) begin
                m_step++;
            end else if (m_words == 2) begin
                m_redir = 1;
            end
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e = mk_exp(16'h0, 0, 0, 0, 32'h0, 0, 0);
        if (m_kind != K_NONE) begin
            e.stall = 1; e.busy = 1; e.pc = m_tgt;
            if (m_redir) begin
                e.cp = 1;
            end else if (m_step < n_ops(m_kind)) begin
                e.inj = op_of(m_kind, m_step);
                e.iv  = 1;
                e.ack = (m_kind == K_INT) && (m_step == 0);
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    exp_t z;

    initial begin
        drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
        z = mk_exp(16'h0, 0, 0, 0, 32'h0, 0, 0);

        // Reset, idle, CALL with stray pops, INT+CALL collision, reset in CALL_HI.
        add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, z);
        add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, z);
        add(0, 0, 0, 0, 16'h0000, 1, 16'hDEAD, z);
        add(0, 0, 1, 0, 16'h0F0F, 1, 16'hDEAD, mk_exp(16'h6008, 1, 1, 0, 32'h0000_0F0F, 0, 1));
        add(0, 0, 0, 0, 16'hAAAA, 1, 16'hDEAD, mk_exp(16'h6009, 1, 1, 0, 32'h0000_0F0F, 0, 1));
        add(0, 0, 0, 0, 16'hAAAA, 1, 16'hDEAD, mk_exp(16'h0000, 0, 1, 1, 32'h0000_0F0F, 0, 1));
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, z);
        add(0, 1, 1, 0, 16'h1111, 0, 16'h0000, mk_exp(16'h6008, 1, 1, 0, 32'h0000_0020, 1, 1));
        add(0, 0, 1, 0, 16'h1111, 0, 16'h0000, mk_exp(16'h6009, 1, 1, 0, 32'h0000_0020, 0, 1));
        add(0, 0, 1, 0, 16'h1111, 0, 16'h0000, mk_exp(16'h600A, 1, 1, 0, 32'h0000_0020, 0, 1));
        add(0, 0, 1, 0, 16'h1111, 0, 16'h0000, mk_exp(16'h0000, 0, 1, 1, 32'h0000_0020, 0, 1));
        add(0, 0, 1, 0, 16'h1111, 0, 16'h0000, z);
        add(0, 0, 1, 0, 16'h1111, 0, 16'h0000, mk_exp(16'h6008, 1, 1, 0, 32'h0000_1111, 0, 1));
        add(0, 0, 0, 0, 16'h1111, 0, 16'h0000, mk_exp(16'h6009, 1, 1, 0, 32'h0000_1111, 0, 1));
        add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, z);
        add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, z);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].intr, vecs[i].call, vecs[i].ret,
                  vecs[i].tgt, vecs[i].mv, vecs[i].md);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e);
        end

        // RET with the second word arriving three cycles after the first.
        drive(0, 0, 0, 1, 16'h0, 1, 16'hBEEF);
        tick(); check_outs("ret_hi", mk_exp(16'h7009, 1, 1, 0, 32'h0, 0, 1));
        drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
        tick(); check_outs("ret_lo", mk_exp(16'h7008, 1, 1, 0, 32'h0, 0, 1));
        drive(0, 0, 0, 0, 16'h0, 1, 16'h1234);
        tick(); check_outs("ret_wait1", mk_exp(16'h0, 0, 1, 0, 32'h1234_0000, 0, 1));
        drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
        tick(); check_outs("ret_wait2", mk_exp(16'h0, 0, 1, 0, 32'h1234_0000, 0, 1));
        tick(); check_outs("ret_wait3", mk_exp(16'h0, 0, 1, 0, 32'h1234_0000, 0, 1));
        drive(0, 0, 0, 0, 16'h0, 1, 16'h5678);
        tick(); check_outs("ret_redir", mk_exp(16'h0, 0, 1, 1, 32'h1234_5678, 0, 1));
        drive(0, 0, 0, 0, 16'h0, 1, 16'h9999);
        tick(); check_outs("ret_idle", z);

        // Random traffic against the model, starting from a clean reset.
        drive(1, 0, 0, 0, 16'h0, 0, 16'h0);
        tick(); check_outs("rnd_reset", model_exp());
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  16'($urandom),
                  $urandom_range(0, 2) == 0,
                  16'($urandom));
            tick();
            check_outs($sformatf("rnd%0d", c), model_exp());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_inject_ctrl.md
# seq_inject_ctrl

Sequencer that owns instruction injection into the decode stage for multi-cycle control-flow macro-ops: CALL (push PC low/high, redirect to Rdst), RET (pop PC high/low, redirect to popped value) and hardware interrupt (push PC low/high, push flags, redirect to vector). It arbitrates between the three requesters, drives the single stall line to fetch/decode, and issues the one-cycle PC redirect to the fetch stage.

## Interface
- OP_PUSH_PC_LOW, 16'h6008, injected push of PC[15:0]
- OP_PUSH_PC_HIGH, 16'h6009, injected push of PC[31:16]
- OP_PUSH_FLAGS, 16'h600A, injected push of flag register
- OP_POP_PC_HIGH, 16'h7009, injected pop into PC[31:16]
- OP_POP_PC_LOW, 16'h7008, injected pop into PC[15:0]
- INT_VECTOR, 32'h0000_0020, interrupt redirect address
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- int_req  in  1  level; held by source until int_ack
- call_req  in  1  level; held by decode while CALL is in decode
- ret_req  in  1  level; held by decode while RET is in decode
- target  in  16  Rdst value for CALL, sampled with call_req
- mem_data_in  in  16  popped word from memory stage
- mem_data_valid  in  1  mem_data_in valid this cycle (max one per cycle)
- inj_instr  out  16  instruction injected into decode; 16'h0000 when none
- inj_valid  out  1  inj_instr is a real injected op
- stall  out  1  freeze fetch/decode
- change_pc  out  1  one-cycle PC redirect strobe
- new_pc  out  32  redirect address, valid when change_pc=1
- int_ack  out  1  one-cycle interrupt acknowledge
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALL_LO, CALL_HI, INT_LO, INT_HI, INT_FLAGS, RET_HI, RET_LO, RET_WAIT, REDIRECT. Outputs are Moore-decoded from state plus latched registers.
- Requests sampled only in IDLE. Priority int_req > call_req > ret_req; losers are not queued (requesters hold level).
- IDLE: call → CALL_LO, latch tgt={16'h0,target}. int → INT_LO, tgt=INT_VECTOR. ret → RET_HI, clear pop counter.
- CALL_LO (inj PUSH_PC_LOW) → CALL_HI (inj PUSH_PC_HIGH) → REDIRECT.
- INT_LO (inj PUSH_PC_LOW, int_ack=1) → INT_HI → INT_FLAGS (inj PUSH_FLAGS) → REDIRECT.
- RET_HI (inj POP_PC_HIGH) → RET_LO (inj POP_PC_LOW) → RET_WAIT (inj 0, inj_valid=0). First mem_data_valid captures tgt[31:16], second captures tgt[15:0]; captures accepted in RET_LO and RET_WAIT. Leave RET_WAIT for REDIRECT on the cycle the count reaches 2 (next cycle is REDIRECT). Valid pulses in any other state ignored.
- REDIRECT: change_pc=1, new_pc=tgt, inj_instr=0, inj_valid=0 → IDLE unconditionally.
- stall=1 in every state except IDLE. inj_valid=1 exactly in the push/pop states.
- new_pc drives tgt in all non-IDLE states, 0 in IDLE.

## Timing
- Reset: state=IDLE, tgt=0, pop count=0; all outputs 0 in the cycle after reset edge. Reset in any state aborts sequence; no change_pc issued.
- CALL: request seen at edge E0; CALL_LO cycle E0–E1, CALL_HI E1–E2, REDIRECT E2–E3, IDLE from E3. Stall 3 cycles.
- INT: stall 4 cycles; int_ack high only during INT_LO.
- RET: minimum 3 cycles stall + REDIRECT when both pops return by end of RET_WAIT's first cycle; unbounded wait otherwise.
- Simultaneous int_req and call_req in IDLE: INT sequence first; CALL starts at earliest the cycle after REDIRECT→IDLE (one IDLE cycle between sequences).
- Request deasserted mid-sequence: sequence completes.

## Structure
- Package pipe_ctrl_pkg: opcode constants (OP_*), INT_VECTOR default, state enum.
- Sub-module pc_assembler: 2-bit pop counter plus high/low halfword capture, with clear, done flag and 32-bit output.

## Test plan
- Reset held 2 cycles then released, no requests → all outputs 0, busy=0.
- call_req=1, target=16'h0F0F → cycle1 inj 16'h6008 stall=1; cycle2 16'h6009; cycle3 change_pc=1 new_pc=32'h0000_0F0F; cycle4 stall=0.
- int_req and call_req together → int_ack cycle1, inj 6008,6009,600A, new_pc=32'h20; then one IDLE cycle; then CALL sequence.
- ret_req; mem_data_valid with 16'h1234 in RET_LO and 16'h5678 three cycles later → stall held in RET_WAIT; change_pc=1 new_pc=32'h1234_5678.
- reset asserted during CALL_HI → next cycle IDLE, change_pc never asserted, stall=0.
- mem_data_valid pulses in IDLE and CALL states → ignored; subsequent RET captures only its own two words.
